// File: rtl/lfsr_32_7_6_pkg.sv
// Shared definitions for the LFSR_32_7_6 descrambler: FSM states, history
// length and the keystream tap positions within the history register.
package lfsr_32_7_6_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int LFSR_LEN = 32;

    // Taps into H (H[j] = k[n-1-j]) giving k[n-1], k[n-26], k[n-27], k[n-31]
    localparam int TAP_0  = 0;
    localparam int TAP_25 = 25;
    localparam int TAP_26 = 26;
    localparam int TAP_30 = 30;

endpackage

// File: rtl/lfsr_32_7_6_predictor.sv
// Keystream history and next-bit predictor. Holds H, shifts in either the
// received bit (while acquiring) or its own prediction (verify / locked),
// and reports whether the next shift would leave H nonzero.
module lfsr_32_7_6_predictor
    import lfsr_32_7_6_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_sel_p,
    input  logic i_din,
    output logic o_p,
    output logic o_nz_next
);

    logic [LFSR_LEN-1:0] r_h;
    logic                w_p;
    logic                w_shift_in;
    logic                w_unused_msb;

    assign w_p          = r_h[TAP_0] ^ r_h[TAP_25] ^ r_h[TAP_26] ^ r_h[TAP_30];
    assign w_shift_in   = i_sel_p ? w_p : i_din;
    // H[31] only ages out of the window; it is never a tap
    assign w_unused_msb = r_h[LFSR_LEN-1];
    assign o_nz_next    = w_shift_in | (|r_h[LFSR_LEN-2:0]);
    assign o_p          = w_p;

    // History shift register; clear wins over a shift in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
        end else if (i_clr) begin
            r_h <= '0;
        end else if (i_en) begin
            r_h <= {r_h[LFSR_LEN-2:0], w_shift_in};
        end
    end

endmodule

// File: rtl/lfsr_32_7_6_descrambler.sv
// Self-synchronising receive descrambler for the LFSR_32_7_6 keystream.
// Acquires keystream phase from a zero-plaintext training run, verifies the
// prediction for VERIFY_LEN bits, then XORs the predicted keystream onto din.
module lfsr_32_7_6_descrambler
    import lfsr_32_7_6_pkg::*;
#(
    parameter int VERIFY_LEN = 64,
    parameter int MISS_TOL   = 0,
    parameter int FAIL_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              resync,
    output logic              dout,
    output logic              dout_valid,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam int              MW         = $clog2(MISS_TOL + 2);
    localparam logic [MW-1:0]   MISS_TOL_V = MW'(MISS_TOL);
    localparam logic [6:0]      VLAST      = 7'(VERIFY_LEN - 1);
    localparam logic [6:0]      ACQ_LAST   = 7'(LFSR_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [6:0]        r_bit_cnt;
    logic [6:0]        w_bit_cnt_nxt;
    logic [MW-1:0]     r_miss_cnt;
    logic [MW-1:0]     w_miss_cnt_nxt;
    logic [MW-1:0]     w_miss_sum;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic              r_dout;
    logic              r_dout_valid;

    logic              w_p;
    logic              w_nz_next;
    logic              w_h_en;
    logic              w_h_clr;
    logic              w_sel_p;
    logic              w_fail_inc;
    logic              w_mismatch;

    lfsr_32_7_6_predictor u_pred (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_en      (w_h_en),
        .i_clr     (w_h_clr),
        .i_sel_p   (w_sel_p),
        .i_din     (din),
        .o_p       (w_p),
        .o_nz_next (w_nz_next)
    );

    assign w_mismatch = din ^ w_p;
    assign w_miss_sum = r_miss_cnt + MW'(w_mismatch);

    // Next-state, counter and history-control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        w_h_en         = 1'b0;
        w_h_clr        = 1'b0;
        w_sel_p        = 1'b0;
        w_fail_inc     = 1'b0;
        if (resync) begin
            w_state_nxt    = ACQUIRE;
            w_bit_cnt_nxt  = '0;
            w_miss_cnt_nxt = '0;
            w_h_clr        = 1'b1;
        end else if (din_valid) begin
            case (r_state)
                ACQUIRE: begin
                    w_h_en = 1'b1;
                    if ((r_bit_cnt >= ACQ_LAST) && w_nz_next) begin
                        w_state_nxt   = VERIFY;
                        w_bit_cnt_nxt = '0;
                    end else if (r_bit_cnt < ACQ_LAST) begin
                        w_bit_cnt_nxt = r_bit_cnt + 7'd1;
                    end
                end
                VERIFY: begin
                    w_h_en  = 1'b1;
                    w_sel_p = 1'b1;
                    if (w_miss_sum > MISS_TOL_V) begin
                        w_state_nxt    = ACQUIRE;
                        w_bit_cnt_nxt  = '0;
                        w_miss_cnt_nxt = '0;
                        w_h_clr        = 1'b1;
                        w_fail_inc     = 1'b1;
                    end else if (r_bit_cnt == VLAST) begin
                        w_state_nxt    = LOCKED;
                        w_bit_cnt_nxt  = '0;
                        w_miss_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt  = r_bit_cnt + 7'd1;
                        w_miss_cnt_nxt = w_miss_sum;
                    end
                end
                LOCKED: begin
                    w_h_en  = 1'b1;
                    w_sel_p = 1'b1;
                end
                default: begin
                    w_state_nxt = ACQUIRE;
                end
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ACQUIRE;
            r_bit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    // Saturating count of verification failures; resync leaves it alone
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fail_cnt <= '0;
        end else if (w_fail_inc && (r_fail_cnt != {FAIL_W{1'b1}})) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    // Registered descrambled output; dout holds its last value when idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= din_valid && !resync && (r_state == LOCKED);
            if (din_valid && !resync && (r_state == LOCKED)) begin
                r_dout <= din ^ w_p;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign locked     = (r_state == LOCKED);
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_lfsr_32_7_6_descrambler.sv
// Directed bench for lfsr_32_7_6_descrambler: clean lock, idle zeros,
// verify failure and relock, gapped valid, resync and mid-verify reset.
module tb_lfsr_32_7_6_descrambler;

    logic       clock;
    logic       reset_n;
    logic       din;
    logic       din_valid;
    logic       resync;
    logic       dout;
    logic       dout_valid;
    logic       locked;
    logic [7:0] fail_cnt;

    int   n_cmp;
    int   n_err;
    logic k [0:2047];

    lfsr_32_7_6_descrambler #(
        .VERIFY_LEN (64),
        .MISS_TOL   (0),
        .FAIL_W     (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .resync     (resync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .fail_cnt   (fail_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic pay_bit(input int m);
        logic [7:0] a;
        a = 8'hA5;
        return a[7 - (m % 8)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1ns after the edge
    task automatic step(input logic b, input logic v, input logic rs);
        din       = b;
        din_valid = v;
        resync    = rs;
        @(posedge clock);
        #1;
        din_valid = 1'b0;
        resync    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_clean(input bit gap);
        logic plain;
        for (int n = 0; n < 96 + 1024; n++) begin
            plain = (n < 96) ? 1'b0 : pay_bit(n - 96);
            step(k[n] ^ plain, 1'b1, 1'b0);
            chk("locked", 32'(locked), 32'(n >= 95));
            chk("dout_valid", 32'(dout_valid), 32'(n >= 96));
            if (n >= 96) chk("dout", 32'(dout), 32'(pay_bit(n - 96)));
            else         chk("dout_idle", 32'(dout), 32'd0);
            if (gap) begin
                step(1'b0, 1'b0, 1'b0);
                chk("gap_dout_valid", 32'(dout_valid), 32'd0);
                if (n >= 96) chk("gap_dout_hold", 32'(dout), 32'(pay_bit(n - 96)));
            end
        end
        chk("clean_fail_cnt", 32'(fail_cnt), 32'd0);
    endtask

    initial begin
        clock     = 1'b0;
        reset_n   = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        resync    = 1'b0;
        n_cmp     = 0;
        n_err     = 0;

        // Transmitter keystream from the all-zero state
        for (int i = 0; i < 31; i++) k[i] = 1'b0;
        k[31] = 1'b1;
        for (int i = 32; i < 2048; i++) k[i] = k[i-1] ^ k[i-26] ^ k[i-27] ^ k[i-31];

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Clean lock with 0xA5 payload
        run_clean(1'b0);

        // Same stream with din_valid every other cycle
        do_reset();
        run_clean(1'b1);

        // All-zero input never locks
        do_reset();
        for (int n = 0; n < 500; n++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("zero_locked", 32'(locked), 32'd0);
            chk("zero_dout_valid", 32'(dout_valid), 32'd0);
            chk("zero_fail_cnt", 32'(fail_cnt), 32'd0);
        end

        // Verify failure on training bit 40, then relock
        do_reset();
        for (int n = 0; n <= 40; n++) begin
            step(k[n] ^ (n == 40), 1'b1, 1'b0);
            if (n == 39) chk("vf_fail_before", 32'(fail_cnt), 32'd0);
        end
        chk("vf_fail_after", 32'(fail_cnt), 32'd1);
        chk("vf_locked_after", 32'(locked), 32'd0);
        for (int n = 41; n <= 137; n++) begin
            step(k[n], 1'b1, 1'b0);
            chk("vf_relock", 32'(locked), 32'(n >= 136));
        end
        chk("vf_dout_valid", 32'(dout_valid), 32'd1);
        chk("vf_dout", 32'(dout), 32'd0);
        chk("vf_fail_keep", 32'(fail_cnt), 32'd1);

        // Asynchronous reset while locked with a nonzero fail count
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_dout_valid", 32'(dout_valid), 32'd0);
        chk("arst_fail_cnt", 32'(fail_cnt), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Resync at payload bit 200
        for (int n = 0; n < 296; n++) begin
            step(k[n] ^ ((n < 96) ? 1'b0 : pay_bit(n - 96)), 1'b1, 1'b0);
        end
        chk("rs_locked_before", 32'(locked), 32'd1);
        chk("rs_dout_before", 32'(dout), 32'(pay_bit(199)));
        step(k[296] ^ pay_bit(200), 1'b1, 1'b1);
        chk("rs_locked", 32'(locked), 32'd0);
        chk("rs_dout_valid", 32'(dout_valid), 32'd0);
        chk("rs_fail_cnt", 32'(fail_cnt), 32'd0);

        // Reset mid-VERIFY at bit 60, then a full reacquire
        do_reset();
        for (int n = 0; n <= 60; n++) step(k[n], 1'b1, 1'b0);
        chk("mv_locked_pre", 32'(locked), 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mv_locked", 32'(locked), 32'd0);
        chk("mv_dout_valid", 32'(dout_valid), 32'd0);
        chk("mv_dout", 32'(dout), 32'd0);
        chk("mv_fail_cnt", 32'(fail_cnt), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 61; n <= 157; n++) begin
            step(k[n], 1'b1, 1'b0);
            chk("mv_relock", 32'(locked), 32'(n >= 156));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_32_7_6_descrambler.md
# lfsr_32_7_6_descrambler

Receive-side counterpart of the LFSR_32_7_6 additive scrambler. It recovers plaintext from a scrambled serial bit stream without a shared reset. It acquires the transmitter's keystream phase from a zero-plaintext training run, verifies the lock, then XORs the predicted keystream onto the payload. It sits directly after the serial link receiver and ahead of any framing logic.

## Interface
- VERIFY_LEN, 64: valid bits checked in VERIFY before declaring lock (1..127)
- MISS_TOL, 0: mismatches tolerated in VERIFY; exceeding it fails verification
- FAIL_W, 8: width of the saturating failure counter
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- din  in  1  received scrambled bit
- din_valid  in  1  din qualifier; the block advances only on valid cycles
- resync  in  1  single-cycle request to abandon lock and re-acquire
- dout  out  1  descrambled bit, registered
- dout_valid  out  1  dout qualifier; asserted only in LOCKED
- locked  out  1  high while in LOCKED
- fail_cnt  out  FAIL_W  saturating count of VERIFY failures

## Operation
- Keystream model: the transmitter's keystream k obeys k[n] = k[n-1] ^ k[n-26] ^ k[n-27] ^ k[n-31].
- From an all-zero transmitter state, the keystream is k[0..30]=0, then k[31]=k[32]=1.
- History register H, 32 bits: H[0] is the newest keystream bit, H[j] = k[n-1-j].
- Predicted bit: p = H[0] ^ H[25] ^ H[26] ^ H[30].
- Bit counter: 7 bits. Mismatch counter: sized to hold MISS_TOL+1.
- FSM:
  - ACQUIRE (reset state): each valid bit shifts din into H (training plaintext is zero, so din = k). After at least 32 valid bits, the FSM moves to VERIFY on the first valid bit that leaves H nonzero. An all-zero H never exits ACQUIRE; the window keeps sliding.
  - VERIFY: each valid bit compares din with p and shifts p (not din) into H. If mismatches exceed MISS_TOL: go to ACQUIRE, clear H and both counters, and increment fail_cnt (saturating at all-ones). After VERIFY_LEN valid bits within tolerance: go to LOCKED.
  - LOCKED: each valid bit shifts p into H. dout <= din ^ p and dout_valid <= 1. No error checking in this state.
- resync=1 in any state: go to ACQUIRE and clear H and counters; fail_cnt is unchanged. resync takes priority over a simultaneous din_valid.
- Invalid cycles: no change to H, counters, or FSM, and dout_valid <= 0.

## Timing
- Reset (asynchronous, immediate): state ACQUIRE; H, counters, dout, dout_valid, locked and fail_cnt all 0.
- Latency: dout/dout_valid appear one cycle after the din_valid sample.
- Lock latency: 32 + VERIFY_LEN valid bits. locked rises in the cycle after the VERIFY_LEN-th verify bit is sampled. The first dout_valid follows the next valid bit.
- locked and dout_valid drop the cycle after a sampled resync.
- Reset asserted mid-operation discards all progress. A deassertion resumes ACQUIRE on the next rising edge.

## Structure
- Package lfsr_32_7_6_pkg:
  - state enum {ACQUIRE, VERIFY, LOCKED}
  - tap-index constants 0/25/26/30
  - LFSR_LEN=32
- One sub-module, lfsr_32_7_6_predictor: owns H, the shift-in select (din or p), clear and enable, and outputs p.
- The FSM and counters stay in the top module.

## Test plan
- Clean lock: bench model of the scrambler from the zero state, 32+64 zero-plaintext bits, then the payload repeating 0xA5 MSB-first.
  - Required: locked rises exactly 96 valid bits in.
  - Required: dout reproduces 0xA5 with no errors for 1024 bits; fail_cnt=0.
- All-zero din for 500 valid bits -> locked=0, dout_valid=0, fail_cnt=0 throughout.
- Verify failure with MISS_TOL=0: flip training bit index 40.
  - Required: return to ACQUIRE and fail_cnt=1.
  - Required: relock after 96 further clean bits.
- din_valid toggled every other cycle (same data as the clean-lock case) -> identical dout sequence, with dout_valid only after valid samples.
- resync pulsed at payload bit 200 (same cycle as din_valid=1) -> locked=0 the next cycle, and that bit is not output.
- reset_n pulled low mid-VERIFY (bit 60) -> all outputs 0 within the same cycle; a full 96-bit reacquire is required afterwards.
